// File: rtl/fma_issue_ctrl.sv
// Issue controller for the FMA datapath: round-robin arbitration of two requesters,
// a bubble-collapsing valid/tag pipeline, and result return. Optional flush: FMA_ISSUE_FLUSH_EN.
module fma_issue_ctrl #(
  parameter int PARM_EXP    = 8,
  parameter int PARM_MANT   = 23,
  parameter int PARM_STAGES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
`ifdef FMA_ISSUE_FLUSH_EN
  input  logic                         flush_i,
`endif
  input  logic                         req0_valid_i,
  output logic                         req0_ready_o,
  input  logic [1:0]                   req0_op_i,
  input  logic [PARM_EXP+PARM_MANT:0]  req0_a_i,
  input  logic [PARM_EXP+PARM_MANT:0]  req0_b_i,
  input  logic [PARM_EXP+PARM_MANT:0]  req0_c_i,
  input  logic                         req1_valid_i,
  output logic                         req1_ready_o,
  input  logic [1:0]                   req1_op_i,
  input  logic [PARM_EXP+PARM_MANT:0]  req1_a_i,
  input  logic [PARM_EXP+PARM_MANT:0]  req1_b_i,
  input  logic [PARM_EXP+PARM_MANT:0]  req1_c_i,
  output logic [PARM_EXP+PARM_MANT:0]  dp_a_o,
  output logic [PARM_EXP+PARM_MANT:0]  dp_b_o,
  output logic [PARM_EXP+PARM_MANT:0]  dp_c_o,
  output logic                         dp_sub_sign_o,
  output logic                         dp_neg_o,
  output logic [PARM_STAGES-1:0]       dp_stage_en_o,
  input  logic [PARM_EXP+PARM_MANT:0]  dp_result_i,
  input  logic [4:0]                   dp_flags_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [PARM_EXP+PARM_MANT:0]  res_o,
  output logic [4:0]                   res_flags_o,
  output logic                         res_tag_o,
  output logic                         busy_o
);

  localparam int W = 1 + PARM_EXP + PARM_MANT;
  localparam int L = PARM_STAGES - 1;

  logic [PARM_STAGES-1:0] v_q, v_d;
  logic [PARM_STAGES-1:0] tag_q, tag_d;
  logic [PARM_STAGES-1:0] adv;
  logic                   rr_q, rr_d;
  logic [W-1:0]           dp_a_q, dp_a_d, dp_b_q, dp_b_d, dp_c_q, dp_c_d;
  logic                   dp_sub_q, dp_sub_d, dp_neg_q, dp_neg_d;

  logic       flush;
  logic       accept, issue, grant0, grant1;
  logic [1:0] op_sel;
  logic [W-1:0] a_sel, b_sel, c_sel;

`ifdef FMA_ISSUE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Advance chain from the output backwards; a flush blocks consumption.
  always_comb begin
    logic chain;
    chain  = ~v_q[L] | (res_ready_i & ~flush);
    adv    = '0;
    adv[L] = chain;
    for (int k = L - 1; k >= 0; k--) begin
      chain  = ~v_q[k+1] | chain;
      adv[k] = chain;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    accept = rst_ni & ~flush & (~v_q[0] | adv[0]);
    grant0 = req0_valid_i & (~req1_valid_i | ~rr_q);
    grant1 = req1_valid_i & (~req0_valid_i |  rr_q);
    issue  = accept & (req0_valid_i | req1_valid_i);

    op_sel = grant1 ? req1_op_i : req0_op_i;
    a_sel  = grant1 ? req1_a_i  : req0_a_i;
    b_sel  = grant1 ? req1_b_i  : req0_b_i;
    c_sel  = grant1 ? req1_c_i  : req0_c_i;

    dp_stage_en_o    = '0;
    dp_stage_en_o[0] = issue;
    for (int k = 1; k <= L; k++) begin
      dp_stage_en_o[k] = adv[k-1] & v_q[k-1] & ~flush;
    end
  end

  always_comb begin
    v_d      = v_q;
    tag_d    = tag_q;
    rr_d     = rr_q;
    dp_a_d   = dp_a_q;
    dp_b_d   = dp_b_q;
    dp_c_d   = dp_c_q;
    dp_sub_d = dp_sub_q;
    dp_neg_d = dp_neg_q;

    if (accept) begin
      v_d[0] = issue;
    end
    if (issue) begin
      tag_d[0] = grant1;
      rr_d     = ~grant1;
      dp_a_d   = a_sel;
      dp_b_d   = b_sel;
      dp_c_d   = c_sel;
      // Product sign (B^C^op[1]) against addend sign (A^op[0]); differing signs mean subtract.
      dp_sub_d = a_sel[W-1] ^ b_sel[W-1] ^ c_sel[W-1] ^ op_sel[0] ^ op_sel[1];
      dp_neg_d = op_sel[1];
    end

    for (int k = 1; k <= L; k++) begin
      if (adv[k-1]) begin
        v_d[k] = v_q[k-1];
      end
      if (adv[k-1] & v_q[k-1]) begin
        tag_d[k] = tag_q[k-1];
      end
    end

    if (flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      v_q      <= '0;
      tag_q    <= '0;
      rr_q     <= 1'b0;
      dp_a_q   <= '0;
      dp_b_q   <= '0;
      dp_c_q   <= '0;
      dp_sub_q <= 1'b0;
      dp_neg_q <= 1'b0;
    end else begin
      v_q      <= v_d;
      tag_q    <= tag_d;
      rr_q     <= rr_d;
      dp_a_q   <= dp_a_d;
      dp_b_q   <= dp_b_d;
      dp_c_q   <= dp_c_d;
      dp_sub_q <= dp_sub_d;
      dp_neg_q <= dp_neg_d;
    end
  end

  assign req0_ready_o  = accept & grant0;
  assign req1_ready_o  = accept & grant1;
  assign dp_a_o        = dp_a_q;
  assign dp_b_o        = dp_b_q;
  assign dp_c_o        = dp_c_q;
  assign dp_sub_sign_o = dp_sub_q;
  assign dp_neg_o      = dp_neg_q;
  assign res_valid_o   = v_q[L] & ~flush;
  assign res_tag_o     = tag_q[L];
  assign res_o         = dp_result_i;
  assign res_flags_o   = dp_flags_i;
  assign busy_o        = |v_q;

endmodule
